// File: rtl/riscv_controller_if.sv
// Control bundle between the multicycle RISC-V controller and its datapath.
// master: the controller (reads instruction fields and flags, drives the enables and selects).
// slave: the datapath side.
interface riscv_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] Imm_Src;

    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, Imm_Src
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUControl, Imm_Src
    );
endinterface

// File: rtl/riscv_controller.sv
// Multicycle RISC-V (RV32I subset) controller: Moore main FSM, ALU decoder
// and immediate-format decoder.
module riscv_controller (
    input  logic                clk,
    input  logic                rst_n,
    riscv_controller_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ, S_LUI
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_pcwrite;
    logic       w_adrsrc;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [2:0] w_alucontrol;
    logic [2:0] w_immsrc;

    // State register: reset parks the FSM in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Next-state logic: DECODE dispatches on the opcode, unknown opcodes refetch.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECUTER;
                    7'b0010011:             w_next = S_EXECUTEI;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100011:             w_next = S_BEQ;
                    7'b0110111:             w_next = S_LUI;
                    default:                w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore outputs per state; anything not set in a state stays 0.
    always_comb begin
        w_pcwrite   = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_pcwrite   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
            end
            S_MEMREAD:  w_adrsrc = 1'b1;
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
            end
            S_EXECUTEI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
            end
            S_ALUWB:    w_regwrite = 1'b1;
            S_JAL: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b10;
                w_pcwrite = 1'b1;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                // funct3[0] turns beq into bne
                w_pcwrite = bus.zero ^ bus.funct3[0];
            end
            S_LUI: begin
                w_resultsrc = 2'b11;
                w_regwrite  = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder: R-type with funct7b5 selects sub, I-type never does.
    always_comb begin
        w_alucontrol = 3'b000;
        case (w_aluop)
            2'b01: w_alucontrol = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  w_alucontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  w_alucontrol = 3'b101;
                    3'b100:  w_alucontrol = 3'b100;
                    3'b110:  w_alucontrol = 3'b011;
                    3'b111:  w_alucontrol = 3'b010;
                    default: w_alucontrol = 3'b000;
                endcase
            end
            default: w_alucontrol = 3'b000;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (bus.op)
            7'b0100011: w_immsrc = 3'b001;
            7'b1100011: w_immsrc = 3'b010;
            7'b0110111: w_immsrc = 3'b011;
            7'b1101111: w_immsrc = 3'b100;
            default:    w_immsrc = 3'b000;
        endcase
    end

    // Write enables are gated by rst_n so an asserted reset kills them before the next edge.
    assign bus.PCWrite    = w_pcwrite  & rst_n;
    assign bus.IRWrite    = w_irwrite  & rst_n;
    assign bus.MemWrite   = w_memwrite & rst_n;
    assign bus.RegWrite   = w_regwrite & rst_n;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ALUControl = w_alucontrol;
    assign bus.Imm_Src    = w_immsrc;

endmodule

// File: doc/riscv_controller.md
RISCV_CONTROLLER -- requirements
Module: riscv_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  7  opcode, instr[6:0], from the instruction register.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 PCWrite  output  1  PC register enable.
REQ-009 AdrSrc  output  1  memory address select: 0=PC, 1=ALU result register.
REQ-010 MemWrite  output  1  data memory write enable.
REQ-011 IRWrite  output  1  instruction register and OldPC enable.
REQ-012 RegWrite  output  1  register file write enable.
REQ-013 ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt.
REQ-014 ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=rs1.
REQ-015 ALUSrcB  output  2  ALU B select: 00=rs2, 01=ImmExt, 10=constant 4.
REQ-016 ALUControl  output  3  ALU operation: add 000, sub 001, and 010, or 011, xor 100, slt 101.
REQ-017 Imm_Src  output  3  immediate format for the sign extender: I 000, S 001, B 010, U 011, J 100.

Function
REQ-018 The state register SHALL be a Moore FSM; outputs not listed for a state SHALL be 0.
REQ-019 FETCH SHALL drive IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, and SHALL go to DECODE.
REQ-020 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-021 DECODE SHALL branch on op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1101111->JAL, 1100011->BEQ, 0110111->LUI, any other op->FETCH.
REQ-022 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to MEMREAD if op[5]=0 and to MEMWRITE if op[5]=1.
REQ-023 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, then go to MEMWB.
REQ-024 MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-025 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1, then go to FETCH.
REQ-026 EXECUTER SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10; both SHALL go to ALUWB.
REQ-027 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-028 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-029 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, then go to FETCH.
REQ-030 In BEQ, PCWrite SHALL be (zero XOR funct3[0]): funct3=000 is beq, funct3=001 is bne.
REQ-031 LUI SHALL drive ResultSrc=11, RegWrite=1, then go to FETCH.
REQ-032 ALU decode SHALL be: ALUOp 00->000; ALUOp 01->001.
REQ-033 For ALUOp 10, funct3 SHALL decode as: 000->001 if (op[5] AND funct7b5) else 000; 010->101; 100->100; 110->011; 111->010; other funct3->000.
REQ-034 Imm_Src SHALL be combinational from op in every state: 0000011/0010011->000, 0100011->001, 1100011->010, 0110111->011, 1101111->100, otherwise 000.
REQ-035 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type ALU and jal 4 cycles; beq/bne and lui 3 cycles; illegal op 2 cycles.

Reset
REQ-036 While rst_n=0, the state SHALL be FETCH, and PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0 combinationally.
REQ-037 Reset asserted in any state SHALL abort the instruction immediately, with no further write enable asserted.
REQ-038 The first rising edge after rst_n rises SHALL execute FETCH with IRWrite=1 and PCWrite=1.

Verification
REQ-039 The bench SHALL check reset: hold rst_n=0 -> all four enables 0, state FETCH; release -> IRWrite=1 and PCWrite=1 in the first cycle only.
REQ-040 The bench SHALL check lw: op=0000011 -> sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; AdrSrc=1 in cycle 4; RegWrite=1 only in cycle 5 with ResultSrc=01; Imm_Src=000.
REQ-041 The bench SHALL check sw: op=0100011 -> MemWrite=1 only in cycle 4; RegWrite never 1; Imm_Src=001.
REQ-042 The bench SHALL check branches: op=1100011 with funct3=000, zero=1 -> PCWrite=1 in cycle 3; zero=0 -> 0; funct3=001 -> inverted results; Imm_Src=010.
REQ-043 The bench SHALL check ALU decode: op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; op=0010011 with the same funct bits -> 000; funct3=111 -> 010.
REQ-044 The bench SHALL check abort cases: op=0000000 -> DECODE then FETCH, no write enable; rst_n=0 during MEMWRITE -> MemWrite drops to 0 before the next edge, and the FSM restarts in FETCH.
